// File: rtl/big_core_pkg.sv
// big_core_pkg: shared types and address map for the big_core load/store unit.
`default_nettype none

package big_core_pkg;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_ILLEGAL  = 2'b01,
    FAULT_UNMAPPED = 2'b10,
    FAULT_TIMEOUT  = 2'b11
  } t_lsu_fault;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEM_RD  = 3'd1,
    S_VGA_GNT = 3'd2,
    S_VGA_RD  = 3'd3,
    S_RSP     = 3'd4
  } t_lsu_state;

  // Load and store funct3 share encodings; BU/HU exist only for loads.
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } t_ls_funct3;

  typedef enum logic [1:0] {
    RGN_NONE = 2'd0,
    RGN_DMEM = 2'd1,
    RGN_CR   = 2'd2,
    RGN_VGA  = 2'd3
  } t_region;

  localparam logic [31:0] DMEM_FLOOR = 32'h0000_2000;
  localparam logic [31:0] DMEM_ROOF  = 32'h0000_3FFF;
  localparam logic [31:0] CR_FLOOR   = 32'h0000_4000;
  localparam logic [31:0] CR_ROOF    = 32'h0000_4FFF;
  localparam logic [31:0] VGA_FLOOR  = 32'h0000_5000;
  localparam logic [31:0] VGA_ROOF   = 32'h0001_15FF;

  function automatic t_region decode_region(input logic [31:0] addr);
    if (addr >= DMEM_FLOOR && addr <= DMEM_ROOF) return RGN_DMEM;
    if (addr >= CR_FLOOR && addr <= CR_ROOF) return RGN_CR;
    if (addr >= VGA_FLOOR && addr <= VGA_ROOF) return RGN_VGA;
    return RGN_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/big_core_lsu_ext.sv
// big_core_lsu_ext: load lane select plus sign/zero extension (combinational).
`default_nettype none

module big_core_lsu_ext
  import big_core_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_data[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_data[31:16] : i_data[15:0];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/big_core_lsu.sv
// big_core_lsu: load/store unit routing accesses to D_MEM, CR and VGA with
// legality checking, lane handling and a VGA grant/read-data timeout.
`default_nettype none

module big_core_lsu
  import big_core_pkg::*;
#(
  parameter int VGA_TIMEOUT = 64
) (
  input  logic        Clock,
  input  logic        Rst_N,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrEn,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWrData,
  input  logic [2:0]  ReqFunct3,
  output logic        RspValid,
  output logic [31:0] RspData,
  output logic [1:0]  RspFault,
  output logic        DMemReq,
  output logic        DMemWrEn,
  output logic [31:0] DMemAddr,
  output logic [3:0]  DMemByteEn,
  output logic [31:0] DMemWrData,
  input  logic [31:0] DMemRdData,
  output logic        CrReq,
  output logic        CrWrEn,
  output logic [31:0] CrAddr,
  output logic [31:0] CrWrData,
  input  logic [31:0] CrRdData,
  output logic        VgaReq,
  input  logic        VgaGnt,
  output logic        VgaWrEn,
  output logic [31:0] VgaAddr,
  output logic [3:0]  VgaByteEn,
  output logic [31:0] VgaWrData,
  input  logic        VgaRdValid,
  input  logic [31:0] VgaRdData
);

  localparam int CW = $clog2(VGA_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(VGA_TIMEOUT - 1);

  t_lsu_state  r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;
  logic        r_is_cr;
  logic        r_vga_wr;
  logic [31:0] r_vga_addr;
  logic [3:0]  r_vga_be;
  logic [31:0] r_vga_wdata;
  logic [31:0] r_rsp_data;
  t_lsu_fault  r_rsp_fault;

  t_region     w_region;
  logic [1:0]  w_off;
  logic        w_illegal;
  t_lsu_fault  w_fault;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_accept;
  logic        w_go;
  logic        w_dmem_go;
  logic        w_cr_go;
  logic        w_vga_req;
  logic [31:0] w_rd_data;
  logic [31:0] w_ext_data;

  always_comb begin
    w_region  = decode_region(ReqAddr);
    w_off     = ReqAddr[1:0];
    w_illegal = 1'b0;
    w_be      = 4'b0000;
    w_wdata   = ReqWrData;
    case (ReqFunct3)
      F3_B: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{ReqWrData[7:0]}};
      end
      F3_H: begin
        w_be      = 4'b0011 << w_off;
        w_wdata   = {2{ReqWrData[15:0]}};
        w_illegal = w_off[0];
      end
      F3_W: begin
        w_be      = 4'b1111;
        w_illegal = (w_off != 2'b00);
      end
      F3_BU: begin
        w_be      = 4'b0001 << w_off;
        w_illegal = ReqWrEn;
      end
      F3_HU: begin
        w_be      = 4'b0011 << w_off;
        w_illegal = ReqWrEn | w_off[0];
      end
      default: w_illegal = 1'b1;
    endcase
    // The control-register block only supports full-word accesses.
    if (w_region == RGN_CR && ReqFunct3 != F3_W) w_illegal = 1'b1;
    if (w_illegal)                  w_fault = FAULT_ILLEGAL;
    else if (w_region == RGN_NONE)  w_fault = FAULT_UNMAPPED;
    else                            w_fault = FAULT_NONE;
  end

  // Rst_N gates acceptance so no strobe escapes while reset is held.
  assign w_accept  = ReqValid & (r_state == S_IDLE) & Rst_N;
  assign w_go      = w_accept & (w_fault == FAULT_NONE);
  assign w_dmem_go = w_go & (w_region == RGN_DMEM);
  assign w_cr_go   = w_go & (w_region == RGN_CR);
  assign w_vga_req = (r_state == S_VGA_GNT);

  assign ReqReady   = (r_state == S_IDLE);
  assign RspValid   = (r_state == S_RSP);
  assign RspData    = r_rsp_data;
  assign RspFault   = r_rsp_fault;

  assign DMemReq    = w_dmem_go;
  assign DMemWrEn   = w_dmem_go & ReqWrEn;
  assign DMemAddr   = w_dmem_go ? ReqAddr : 32'h0;
  assign DMemByteEn = w_dmem_go ? w_be : 4'b0000;
  assign DMemWrData = (w_dmem_go & ReqWrEn) ? w_wdata : 32'h0;

  assign CrReq      = w_cr_go;
  assign CrWrEn     = w_cr_go & ReqWrEn;
  assign CrAddr     = w_cr_go ? ReqAddr : 32'h0;
  assign CrWrData   = (w_cr_go & ReqWrEn) ? ReqWrData : 32'h0;

  assign VgaReq     = w_vga_req;
  assign VgaWrEn    = w_vga_req & r_vga_wr;
  assign VgaAddr    = w_vga_req ? r_vga_addr : 32'h0;
  assign VgaByteEn  = w_vga_req ? r_vga_be : 4'b0000;
  assign VgaWrData  = (w_vga_req & r_vga_wr) ? r_vga_wdata : 32'h0;

  assign w_rd_data = (r_state == S_VGA_RD) ? VgaRdData : (r_is_cr ? CrRdData : DMemRdData);

  big_core_lsu_ext u_ext (
    .i_data   (w_rd_data),
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .o_data   (w_ext_data)
  );

  always_ff @(posedge Clock or negedge Rst_N) begin
    if (!Rst_N) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_off       <= '0;
      r_f3        <= '0;
      r_is_cr     <= 1'b0;
      r_vga_wr    <= 1'b0;
      r_vga_addr  <= '0;
      r_vga_be    <= '0;
      r_vga_wdata <= '0;
      r_rsp_data  <= '0;
      r_rsp_fault <= FAULT_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_off       <= ReqAddr[1:0];
            r_f3        <= ReqFunct3;
            r_is_cr     <= (w_region == RGN_CR);
            r_rsp_data  <= '0;
            r_rsp_fault <= w_fault;
            if (w_fault != FAULT_NONE) begin
              r_state <= S_RSP;
            end else if (w_region == RGN_VGA) begin
              r_vga_wr    <= ReqWrEn;
              r_vga_addr  <= ReqAddr;
              r_vga_be    <= w_be;
              r_vga_wdata <= w_wdata;
              r_cnt       <= '0;
              r_state     <= S_VGA_GNT;
            end else if (ReqWrEn) begin
              r_state <= S_RSP;
            end else begin
              r_state <= S_MEM_RD;
            end
          end
        end
        S_MEM_RD: begin
          r_rsp_data <= w_ext_data;
          r_state    <= S_RSP;
        end
        S_VGA_GNT: begin
          r_cnt <= r_cnt + 1'b1;
          // Grant is checked first so a grant on the expiry cycle still wins.
          if (VgaGnt) begin
            r_state <= r_vga_wr ? S_RSP : S_VGA_RD;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp_fault <= FAULT_TIMEOUT;
            r_state     <= S_RSP;
          end
        end
        S_VGA_RD: begin
          r_cnt <= r_cnt + 1'b1;
          if (VgaRdValid) begin
            r_rsp_data <= w_ext_data;
            r_state    <= S_RSP;
          end else if (r_cnt >= CNT_LAST) begin
            r_rsp_fault <= FAULT_TIMEOUT;
            r_state     <= S_RSP;
          end
        end
        S_RSP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_big_core_lsu.sv
// tb_big_core_lsu: directed vector table, reset sequences and randomized
// transactions checked against a region/lane arithmetic model.
`default_nettype none

module tb_big_core_lsu;

  localparam int TO = 16;

  logic        Clock = 1'b0;
  logic        Rst_N;
  logic        ReqValid, ReqReady, ReqWrEn;
  logic [31:0] ReqAddr, ReqWrData;
  logic [2:0]  ReqFunct3;
  logic        RspValid;
  logic [31:0] RspData;
  logic [1:0]  RspFault;
  logic        DMemReq, DMemWrEn;
  logic [31:0] DMemAddr, DMemWrData, DMemRdData;
  logic [3:0]  DMemByteEn;
  logic        CrReq, CrWrEn;
  logic [31:0] CrAddr, CrWrData, CrRdData;
  logic        VgaReq, VgaGnt, VgaWrEn, VgaRdValid;
  logic [31:0] VgaAddr, VgaWrData, VgaRdData;
  logic [3:0]  VgaByteEn;
  logic [31:0] cur_rd;

  int n_chk = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  big_core_lsu #(.VGA_TIMEOUT(TO)) dut (
    .Clock(Clock), .Rst_N(Rst_N),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrEn(ReqWrEn),
    .ReqAddr(ReqAddr), .ReqWrData(ReqWrData), .ReqFunct3(ReqFunct3),
    .RspValid(RspValid), .RspData(RspData), .RspFault(RspFault),
    .DMemReq(DMemReq), .DMemWrEn(DMemWrEn), .DMemAddr(DMemAddr),
    .DMemByteEn(DMemByteEn), .DMemWrData(DMemWrData), .DMemRdData(DMemRdData),
    .CrReq(CrReq), .CrWrEn(CrWrEn), .CrAddr(CrAddr),
    .CrWrData(CrWrData), .CrRdData(CrRdData),
    .VgaReq(VgaReq), .VgaGnt(VgaGnt), .VgaWrEn(VgaWrEn), .VgaAddr(VgaAddr),
    .VgaByteEn(VgaByteEn), .VgaWrData(VgaWrData),
    .VgaRdValid(VgaRdValid), .VgaRdData(VgaRdData)
  );

  // Single-cycle-latency memories: read word returned the cycle after a read strobe.
  always @(posedge Clock) begin
    DMemRdData <= (DMemReq && !DMemWrEn) ? cur_rd : $urandom;
    CrRdData   <= (CrReq && !CrWrEn) ? cur_rd : $urandom;
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] rd;
    int          g;
    int          r;
    logic [1:0]  ef;
    logic [31:0] ed;
    logic [3:0]  ebe;
    logic [31:0] ewd;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int region_of(input logic [31:0] a);
    if (a >= 32'h2000 && a <= 32'h3FFF) return 1;
    if (a >= 32'h4000 && a <= 32'h4FFF) return 2;
    if (a >= 32'h5000 && a <= 32'h115FF) return 3;
    return 0;
  endfunction

  function automatic bit vga_times_out(input bit wr, input int g, input int r);
    if (g > TO - 1) return 1'b1;
    if (wr) return 1'b0;
    return (r < 0) || (1 + g + r > TO - 1);
  endfunction

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] f3,
                              input logic [31:0] wd, input logic [31:0] rd, input int g,
                              input int r, input logic [1:0] ef, input logic [31:0] ed,
                              input logic [3:0] ebe, input logic [31:0] ewd);
    vec_t v;
    v.wr = wr; v.addr = addr; v.f3 = f3; v.wd = wd; v.rd = rd; v.g = g; v.r = r;
    v.ef = ef; v.ed = ed; v.ebe = ebe; v.ewd = ewd;
    return v;
  endfunction

  // Reference: access size from funct3, lanes by byte arithmetic, extension by subtraction.
  function automatic vec_t model(input vec_t v);
    int     rg, nb, off, be;
    bit     legal;
    longint raw;
    rg  = region_of(v.addr);
    off = int'(v.addr[1:0]);
    nb  = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    legal = v.wr ? (v.f3 <= 3'd2) : (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (off % nb != 0) legal = 1'b0;
    if (rg == 2 && v.f3 != 3'd2) legal = 1'b0;
    be    = ((1 << nb) - 1) << off;
    v.ebe = 4'(be);
    for (int i = 0; i < 4; i++) v.ewd[8*i +: 8] = v.wd[8*(i % nb) +: 8];
    raw = (longint'(v.rd) >> (8 * off)) % (longint'(1) << (8 * nb));
    if (v.f3[2] == 1'b0 && nb < 4 && raw >= (longint'(1) << (8 * nb - 1)))
      raw = raw - (longint'(1) << (8 * nb));
    if (!legal)                                        v.ef = 2'd1;
    else if (rg == 0)                                  v.ef = 2'd2;
    else if (rg == 3 && vga_times_out(v.wr, v.g, v.r)) v.ef = 2'd3;
    else                                               v.ef = 2'd0;
    v.ed = (v.ef == 2'd0 && !v.wr) ? raw[31:0] : 32'h0;
    return v;
  endfunction

  // Entered and left just after a rising edge.
  task automatic run_txn(input vec_t v, input string nm);
    int rg, rsp, vlast;
    bit pre, isv;
    rg  = region_of(v.addr);
    pre = (v.ef == 2'd1 || v.ef == 2'd2);
    isv = !pre && rg == 3;
    if (pre)                                 rsp = 1;
    else if (!isv)                           rsp = v.wr ? 1 : 2;
    else if (vga_times_out(v.wr, v.g, v.r))  rsp = 1 + TO;
    else                                     rsp = v.wr ? 2 + v.g : 3 + v.g + v.r;
    vlast = isv ? 1 + ((v.g < TO - 1) ? v.g : TO - 1) : 0;
    ReqValid = 1'b1; ReqWrEn = v.wr; ReqAddr = v.addr; ReqFunct3 = v.f3; ReqWrData = v.wd;
    cur_rd = v.rd;
    for (int c = 0; c <= rsp + 1; c++) begin
      if (c > 0) begin
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        VgaGnt   = isv && (c == 1 + v.g);
        if (isv && !v.wr && v.r >= 0 && c == 2 + v.g + v.r) begin
          VgaRdValid = 1'b1; VgaRdData = v.rd;
        end else if (isv && c <= 1 + v.g) begin
          VgaRdValid = 1'b1; VgaRdData = $urandom;
        end else begin
          VgaRdValid = 1'b0; VgaRdData = $urandom;
        end
      end
      @(negedge Clock);
      chk({nm, ":ctl"}, {DMemReq, CrReq, VgaReq, RspValid, ReqReady},
          {(c == 0 && !pre && rg == 1), (c == 0 && !pre && rg == 2),
           (isv && c >= 1 && c <= vlast), (c == rsp), (c == 0 || c > rsp)});
      if (c == 0 && !pre && rg == 1) begin
        chk({nm, ":dmem"}, {DMemWrEn, DMemByteEn, DMemAddr}, {v.wr, v.ebe, v.addr});
        if (v.wr) chk({nm, ":dmem_wd"}, DMemWrData, v.ewd);
      end
      if (c == 0 && !pre && rg == 2) begin
        chk({nm, ":cr"}, {CrWrEn, CrAddr}, {v.wr, v.addr});
        if (v.wr) chk({nm, ":cr_wd"}, CrWrData, v.ewd);
      end
      if (isv && (c == 1 || c == vlast)) begin
        chk({nm, ":vga"}, {VgaWrEn, VgaByteEn, VgaAddr}, {v.wr, v.ebe, v.addr});
        if (v.wr) chk({nm, ":vga_wd"}, VgaWrData, v.ewd);
      end
      if (c == rsp) begin
        chk({nm, ":fault"}, RspFault, v.ef);
        if (!v.wr || v.ef != 2'd0) chk({nm, ":data"}, RspData, v.ed);
      end
    end
    @(posedge Clock); #1;
    VgaGnt = 1'b0; VgaRdValid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   seen;

    Rst_N = 1'b0; ReqValid = 1'b1; ReqWrEn = 1'b1; ReqAddr = 32'h2000;
    ReqFunct3 = 3'd2; ReqWrData = 32'hFFFF_FFFF; cur_rd = 32'h0;
    VgaGnt = 1'b0; VgaRdValid = 1'b0; VgaRdData = 32'h0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst_ready", ReqReady, 1'b1);
    chk("rst_rsp", {RspValid, RspFault, RspData}, 0);
    chk("rst_dmem", {DMemReq, DMemWrEn, DMemByteEn, DMemAddr}, 0);
    chk("rst_wdata", {DMemWrData, CrWrData}, 0);
    chk("rst_cr_vga", {CrReq, CrWrEn, CrAddr, VgaReq, VgaWrEn, VgaByteEn}, 0);
    chk("rst_vga_bus", {VgaAddr, VgaWrData}, 0);
    @(posedge Clock); #1;
    ReqValid = 1'b0; Rst_N = 1'b1;
    @(posedge Clock); #1;

    //            wr addr          f3    wdata          rdword        g    r   ef    edata          be     ewd
    tbl.push_back(mk(1, 32'h2004,  3'd2, 32'hDEADBEEF, 32'h0,        0,   0, 2'd0, 32'h0,        4'hF, 32'hDEADBEEF));
    tbl.push_back(mk(1, 32'h2001,  3'd0, 32'h000000A5, 32'h0,        0,   0, 2'd0, 32'h0,        4'h2, 32'hA5A5A5A5));
    tbl.push_back(mk(1, 32'h2002,  3'd1, 32'h0000BEEF, 32'h0,        0,   0, 2'd0, 32'h0,        4'hC, 32'hBEEFBEEF));
    tbl.push_back(mk(0, 32'h2003,  3'd0, 32'h0,        32'h80FF7F01, 0,   0, 2'd0, 32'hFFFFFF80, 4'h8, 32'h0));
    tbl.push_back(mk(0, 32'h2003,  3'd4, 32'h0,        32'h80FF7F01, 0,   0, 2'd0, 32'h00000080, 4'h8, 32'h0));
    tbl.push_back(mk(0, 32'h2002,  3'd1, 32'h0,        32'h80FF7F01, 0,   0, 2'd0, 32'hFFFF80FF, 4'hC, 32'h0));
    tbl.push_back(mk(0, 32'h2000,  3'd5, 32'h0,        32'h80FF7F01, 0,   0, 2'd0, 32'h00007F01, 4'h3, 32'h0));
    tbl.push_back(mk(0, 32'h3FFC,  3'd0, 32'h0,        32'h80FF7F01, 0,   0, 2'd0, 32'h00000001, 4'h1, 32'h0));
    tbl.push_back(mk(0, 32'h2002,  3'd2, 32'h0,        32'h12345678, 0,   0, 2'd1, 32'h0,        4'h0, 32'h0));
    tbl.push_back(mk(0, 32'h0010,  3'd2, 32'h0,        32'h12345678, 0,   0, 2'd2, 32'h0,        4'h0, 32'h0));
    tbl.push_back(mk(1, 32'h4000,  3'd0, 32'h000000FF, 32'h0,        0,   0, 2'd1, 32'h0,        4'h0, 32'h0));
    tbl.push_back(mk(1, 32'h4008,  3'd2, 32'h12345678, 32'h0,        0,   0, 2'd0, 32'h0,        4'hF, 32'h12345678));
    tbl.push_back(mk(0, 32'h4FFC,  3'd2, 32'h0,        32'hCAFEF00D, 0,   0, 2'd0, 32'hCAFEF00D, 4'hF, 32'h0));
    tbl.push_back(mk(1, 32'h5006,  3'd1, 32'h00001234, 32'h0,        3,   0, 2'd0, 32'h0,        4'hC, 32'h12341234));
    tbl.push_back(mk(0, 32'h5000,  3'd2, 32'h0,        32'h0,        0,  -1, 2'd3, 32'h0,        4'hF, 32'h0));
    tbl.push_back(mk(0, 32'h115FE, 3'd1, 32'h0,        32'h80010000, 1,   2, 2'd0, 32'hFFFF8001, 4'hC, 32'h0));
    tbl.push_back(mk(0, 32'h11600, 3'd2, 32'h0,        32'h0,        0,   0, 2'd2, 32'h0,        4'h0, 32'h0));
    tbl.push_back(mk(0, 32'h2000,  3'd3, 32'h0,        32'h0,        0,   0, 2'd1, 32'h0,        4'h0, 32'h0));
    tbl.push_back(mk(1, 32'h0000,  3'd4, 32'h0,        32'h0,        0,   0, 2'd1, 32'h0,        4'h0, 32'h0));
    tbl.push_back(mk(1, 32'h5000,  3'd2, 32'hA5A55A5A, 32'h0,        TO-1,0, 2'd0, 32'h0,        4'hF, 32'hA5A55A5A));
    tbl.push_back(mk(1, 32'h5004,  3'd2, 32'h11112222, 32'h0,        TO,  0, 2'd3, 32'h0,        4'hF, 32'h11112222));
    tbl.push_back(mk(0, 32'h1FFC,  3'd2, 32'h0,        32'h0,        0,   0, 2'd2, 32'h0,        4'h0, 32'h0));
    tbl.push_back(mk(0, 32'h2001,  3'd5, 32'h0,        32'h0,        0,   0, 2'd1, 32'h0,        4'h0, 32'h0));
    for (int i = 0; i < tbl.size(); i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset pulse while a VGA load waits for grant: the access must vanish.
    ReqValid = 1'b1; ReqWrEn = 1'b0; ReqAddr = 32'h5000; ReqFunct3 = 3'd2;
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    @(posedge Clock); #1;
    Rst_N = 1'b0; ReqValid = 1'b1; ReqWrEn = 1'b1; ReqAddr = 32'h2000;
    #2;
    chk("midrst_ready", ReqReady, 1'b1);
    chk("midrst_strobes", {VgaReq, DMemReq, CrReq, RspValid}, 0);
    @(posedge Clock); #1;
    ReqValid = 1'b0; Rst_N = 1'b1;
    seen = 0;
    for (int i = 0; i < TO + 4; i++) begin
      @(negedge Clock);
      if (RspValid || VgaReq) seen++;
    end
    chk("midrst_no_rsp", seen, 0);
    chk("midrst_ready_after", ReqReady, 1'b1);
    @(posedge Clock); #1;

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0, 4: v.addr = 32'h2000 + $urandom_range(0, 32'h1FFF);
        1:    v.addr = 32'h4000 + $urandom_range(0, 32'hFFF);
        2:    v.addr = 32'h5000 + $urandom_range(0, 32'hC5FF);
        default: v.addr = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 32'h1FFF)
                                                       : 32'h11600 + $urandom_range(0, 32'hFFFF);
      endcase
      if ($urandom_range(0, 1) == 0) v.addr[1:0] = 2'b00;
      v.wr = bit'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) v.f3 = 3'($urandom_range(0, 7));
      else if (v.wr)                 v.f3 = 3'($urandom_range(0, 2));
      else                           v.f3 = 3'($urandom_range(0, 5)) & 3'b101 | 3'($urandom_range(0, 1)) << 1;
      v.wd = $urandom;
      v.rd = $urandom;
      v.g  = ($urandom_range(0, 9) == 0) ? TO + 2 : int'($urandom_range(0, 3));
      v.r  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      v = model(v);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/big_core_lsu.md
BIG_CORE_LSU -- requirements
Module: big_core_lsu

Interface
REQ-001 SHALL have parameter VGA_TIMEOUT, default 64, meaning the maximum number of cycles a VGA access may wait for grant plus read data.
REQ-002 SHALL have port Clock  in  1  core clock.
REQ-003 SHALL have port Rst_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports ReqValid in 1 / ReqReady out 1: request handshake from the memory stage.
REQ-005 SHALL have ports ReqWrEn in 1 (1 = store), ReqAddr in 32 (byte address), ReqWrData in 32 (store data), ReqFunct3 in 3 (RV32I load/store funct3).
REQ-006 SHALL have ports RspValid out 1, RspData out 32 (extended load data), RspFault out 2 (t_lsu_fault).
REQ-007 SHALL have D_MEM ports DMemReq out 1, DMemWrEn out 1, DMemAddr out 32, DMemByteEn out 4, DMemWrData out 32, DMemRdData in 32 (read latency 1).
REQ-008 SHALL have CR ports CrReq, CrWrEn, CrAddr, CrWrData, CrRdData, with the same widths, directions and latency as the D_MEM ports and no byte enable.
REQ-009 SHALL have VGA ports VgaReq out 1, VgaGnt in 1, VgaWrEn out 1, VgaAddr out 32, VgaByteEn out 4, VgaWrData out 32, VgaRdValid in 1, VgaRdData in 32.

Function
REQ-010 SHALL decode regions as follows: D_MEM 0x2000-0x3FFF, CR 0x4000-0x4FFF, VGA 0x5000-0x115FF; any other address, including I_MEM 0x0-0x1FFF, is unmapped.
REQ-011 SHALL implement FSM states IDLE, MEM_RD, VGA_GNT, VGA_RD and RSP; ReqReady SHALL be 1 only in IDLE.
REQ-012 SHALL accept a request on ReqValid && ReqReady and produce exactly one single-cycle RspValid pulse for every accepted request.
REQ-013 SHALL apply these legality rules:
- legal loads: LB, LH, LW, LBU, LHU.
- legal stores: SB, SH, SW.
- any other funct3, LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0 -> fault ILLEGAL.
- CR accesses other than LW/SW -> fault ILLEGAL.
REQ-014 SHALL, on a fault, issue no memory strobe and respond in the next cycle with RspData=0 and the fault code; ILLEGAL takes priority over UNMAPPED.
REQ-015 SHALL, for a legal D_MEM or CR access, assert that region's Req (with WrEn, address, enables and data) combinationally in the acceptance cycle only.
REQ-016 SHALL, for a D_MEM or CR store, go to RSP; for a load, go to MEM_RD, capture the read data, and respond in the following cycle (RspValid 2 cycles after acceptance).
REQ-017 SHALL generate byte enables 0001<<addr[1:0] for SB, 0011<<addr[1:0] for SH and 1111 for SW.
REQ-018 SHALL replicate store data as SB byte x4, SH half x2 and SW unchanged.
REQ-019 SHALL select the load lane from addr[1:0], sign-extend LB/LH and zero-extend LBU/LHU.
REQ-020 SHALL, for a VGA access, enter VGA_GNT the cycle after acceptance and hold VgaReq plus registered address, enables and data until the cycle VgaGnt=1 (inclusive).
REQ-021 SHALL, after grant, go to RSP for a store, or to VGA_RD for a load, where it waits for VgaRdValid, captures and extends VgaRdData, then goes to RSP.
REQ-022 SHALL count cycles in VGA_GNT and VGA_RD; on reaching VGA_TIMEOUT it drops VgaReq, goes to RSP with fault TIMEOUT and RspData=0, and ignores any later VgaRdValid.
REQ-023 SHALL drive RspValid=1 only in RSP and then return to IDLE; VgaRdValid outside VGA_RD SHALL be ignored.
REQ-024 SHALL ensure that a simultaneous VgaGnt and timeout expiry resolves as grant.

Reset
REQ-025 SHALL, while Rst_N=0, force state IDLE, the timeout counter to 0, and ReqReady=1.
REQ-026 SHALL, while Rst_N=0, drive RspValid, RspData, RspFault, all Req/WrEn strobes, addresses, enables and write data to 0.
REQ-027 SHALL discard any in-flight access on reset mid-operation and never emit a response for it.

Structure
REQ-028 SHALL place t_lsu_fault (NONE=2'b00, ILLEGAL=2'b01, UNMAPPED=2'b10, TIMEOUT=2'b11), t_lsu_state, a load/store funct3 enum and the region floor/roof constants in big_core_pkg.
REQ-029 SHALL implement lane select and extension in one combinational sub-module, big_core_lsu_ext, reused by the D_MEM, CR and VGA read paths.

Verification
REQ-030 SHALL cover: SW 0x2004 data 0xDEADBEEF -> DMemByteEn=1111 in the acceptance cycle, RspValid next cycle, fault NONE.
REQ-031 SHALL cover: DMemRdData=0x80FF7F01, LB 0x2003 -> RspData=0xFFFFFF80; LBU 0x2003 -> 0x00000080; LH 0x2002 -> 0xFFFF80FF.
REQ-032 SHALL cover: LW 0x2002 -> ILLEGAL, RspData=0, no DMemReq; LW 0x0010 -> UNMAPPED; SB 0x4000 -> ILLEGAL.
REQ-033 SHALL cover: SH 0x5006 data 0x1234 with VgaGnt held low 3 cycles -> VgaReq high 4 cycles, VgaByteEn=1100, VgaWrData=0x12341234, RspValid the cycle after grant.
REQ-034 SHALL cover: LW 0x5000 granted but VgaRdValid never asserted -> TIMEOUT response VGA_TIMEOUT cycles after entering VGA_GNT; Rst_N pulsed low during VGA_GNT -> no response, ReqReady=1.
